// File: rtl/svif_mbox_slave.sv
// Mailbox slave behind the svif arbiter: four 32-bit words, one per master,
// with programmable wait states, ack/err pulses and a saturating access count.
module svif_mbox_slave #(
  parameter int SLV_ID   = 0,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        RW,
  input  logic [31:0] addr,
  input  logic [31:0] DataToSlave,
  output logic [31:0] DataFromSlave,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [15:0] acc_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] ACK  = 3'd2;
  localparam logic [2:0] ERR  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  localparam logic [3:0] SLV   = SLV_ID[3:0];
  localparam logic [3:0] WINIT = WAIT_CYC[3:0];

  logic [2:0]  state;
  logic [2:0]  stateNxt;
  logic [3:0]  wcnt;
  logic        latRW;
  logic [31:0] latAddr;
  logic [31:0] latData;
  logic [31:0] mbox [4];

  logic        decOk;
  logic        same;
  logic        doAcc;
  logic        accRW;
  logic [1:0]  accIdx;
  logic [31:0] accData;

  assign decOk = (addr[31:16] == 16'hFFEF)
              && (addr[15:12] == SLV)
              && (addr[11:8]  == 4'h2)
              && (addr[7:6]   == 2'b00)
              && (addr[3:0]   == 4'h0);

  assign same = sel && (addr == latAddr);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (sel) begin
          if (!decOk)          stateNxt = ERR;
          else if (WINIT == 0) stateNxt = ACK;
          else                 stateNxt = WAIT;
        end
      end
      WAIT: begin
        if (!same)             stateNxt = IDLE;
        else if (wcnt == 4'd1) stateNxt = ACK;
      end
      ACK:     stateNxt = HOLD;
      ERR:     stateNxt = HOLD;
      HOLD:    if (!same) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Zero-wait accesses commit straight from the bus, others from the latch.
  assign doAcc   = (stateNxt == ACK);
  assign accRW   = (state == IDLE) ? RW : latRW;
  assign accIdx  = (state == IDLE) ? addr[5:4] : latAddr[5:4];
  assign accData = (state == IDLE) ? DataToSlave : latData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wcnt          <= '0;
      latRW         <= 1'b0;
      latAddr       <= '0;
      latData       <= '0;
      DataFromSlave <= '0;
      ack           <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
      acc_cnt       <= '0;
      for (int i = 0; i < 4; i++) mbox[i] <= '0;
    end else begin
      state <= stateNxt;
      ack   <= (stateNxt == ACK);
      err   <= (stateNxt == ERR);
      busy  <= (stateNxt != IDLE);
      if (state == IDLE && sel) begin
        latRW   <= RW;
        latAddr <= addr;
        latData <= DataToSlave;
        if (decOk) wcnt <= WINIT;
      end else if (state == WAIT && same && wcnt != 4'd1) begin
        wcnt <= wcnt - 4'd1;
      end
      if (doAcc) begin
        if (accRW) mbox[accIdx] <= accData;
        else       DataFromSlave <= mbox[accIdx];
        if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_svif_mbox_slave.sv
// Directed bench for svif_mbox_slave: one WAIT_CYC=2 instance and one
// zero-wait instance used for the counter saturation scenario.
module tb_svif_mbox_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        selZ = 1'b0;
  logic        RW = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;

  logic [31:0] rdA, rdZ;
  logic        ackA, errA, busyA;
  logic        ackZ, errZ, busyZ;
  logic [15:0] cntA, cntZ;

  int checks = 0;
  int failures = 0;

  svif_mbox_slave #(.SLV_ID(0), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .RW(RW),
    .addr(addr), .DataToSlave(wd),
    .DataFromSlave(rdA), .ack(ackA), .err(errA),
    .busy(busyA), .acc_cnt(cntA)
  );

  svif_mbox_slave #(.SLV_ID(0), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .sel(selZ), .RW(RW),
    .addr(addr), .DataToSlave(wd),
    .DataFromSlave(rdZ), .ack(ackZ), .err(errZ),
    .busy(busyZ), .acc_cnt(cntZ)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task drive(input logic w, input logic [31:0] a,
             input logic [31:0] d);
    sel = 1'b1; RW = w; addr = a; wd = d;
  endtask

  task relBus;
    sel = 1'b0; selZ = 1'b0;
    tick; tick;
  endtask

  task accA(input logic w, input logic [31:0] a,
            input logic [31:0] d);
    drive(w, a, d);
    repeat (3) tick;
    relBus;
  endtask

  task doReset;
    rst = 1'b0; sel = 1'b0; selZ = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task test_reset;
    logic [52:0] o;
    doReset;
    o = {rdA, ackA, errA, busyA, cntA};
    checks++;
    if (o !== 53'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", o);
    end
    accA(1'b1, 32'hFFEF0210, 32'h1111_1111);
    accA(1'b0, 32'hFFEF0210, 32'h0);
    checks++;
    if (rdA !== 32'h1111_1111) begin
      failures++;
      $display("FAIL pre_reset_read got=%h exp=11111111", rdA);
    end
    drive(1'b1, 32'hFFEF0210, 32'h2222_2222);
    tick; tick;
    checks++;
    if (busyA !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_wait got=%b exp=1", busyA);
    end
    rst = 1'b0;
    #1;
    o = {rdA, ackA, errA, busyA, cntA};
    checks++;
    if (o !== 53'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", o);
    end
    sel = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    accA(1'b0, 32'hFFEF0210, 32'h0);
    checks++;
    if (rdA !== 32'h0 || cntA !== 16'd1) begin
      failures++;
      $display("FAIL reset_mbox got=%h/%h exp=0/1", rdA, cntA);
    end
  endtask

  task test_write_read;
    logic [4:0] pat;
    doReset;
    pat = '0;
    drive(1'b1, 32'hFFEF0210, 32'hA5A5_0001);
    for (int k = 0; k < 5; k++) begin
      tick;
      pat[k] = ackA;
    end
    checks++;
    if (pat !== 5'b00100) begin
      failures++;
      $display("FAIL write_ack_timing got=%b exp=00100", pat);
    end
    relBus;
    accA(1'b0, 32'hFFEF0210, 32'h0);
    checks++;
    if (rdA !== 32'hA5A5_0001 || cntA !== 16'd2) begin
      failures++;
      $display("FAIL read_back got=%h/%h exp=a5a50001/2",
               rdA, cntA);
    end
  endtask

  task test_decode_err;
    logic [3:0] ep;
    logic       ap;
    ep = '0; ap = 1'b0;
    drive(1'b1, 32'hFFEF1210, 32'h0000_0BAD);
    for (int k = 0; k < 4; k++) begin
      tick;
      ep[k] = errA;
      ap = ap | ackA;
    end
    checks++;
    if (ep !== 4'b0001 || ap !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got=%b/%b exp=0001/0", ep, ap);
    end
    checks++;
    if (cntA !== 16'd2 || rdA !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL err_side_effect got=%h/%h exp=2/a5a50001",
               cntA, rdA);
    end
    relBus;
    accA(1'b0, 32'hFFEF0210, 32'h0);
    checks++;
    if (rdA !== 32'hA5A5_0001 || cntA !== 16'd3) begin
      failures++;
      $display("FAIL err_mbox got=%h/%h exp=a5a50001/3", rdA, cntA);
    end
  endtask

  task test_abort;
    logic ap;
    accA(1'b1, 32'hFFEF0200, 32'h0000_1234);
    drive(1'b1, 32'hFFEF0200, 32'h0000_DEAD);
    tick;
    sel = 1'b0;
    tick;
    checks++;
    if (busyA !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=0", busyA);
    end
    ap = ackA;
    tick; ap = ap | ackA;
    tick; ap = ap | ackA;
    checks++;
    if (ap !== 1'b0 || cntA !== 16'd4) begin
      failures++;
      $display("FAIL abort_noack got=%b/%h exp=0/4", ap, cntA);
    end
    accA(1'b0, 32'hFFEF0200, 32'h0);
    checks++;
    if (rdA !== 32'h0000_1234 || cntA !== 16'd5) begin
      failures++;
      $display("FAIL abort_mbox got=%h/%h exp=1234/5", rdA, cntA);
    end
  endtask

  task test_back_to_back;
    int n;
    int lat;
    n = 0;
    lat = 0;
    drive(1'b1, 32'hFFEF0220, 32'h00C0_FFEE);
    repeat (20) begin
      tick;
      n += int'(ackA);
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL held_grant got=%0d exp=1", n);
    end
    addr = 32'hFFEF0230;
    wd = 32'h0000_5A5A;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (ackA && lat == 0) lat = k;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL switch_latency got=%0d exp=4", lat);
    end
    relBus;
    checks++;
    if (cntA !== 16'd7) begin
      failures++;
      $display("FAIL switch_count got=%h exp=7", cntA);
    end
    accA(1'b0, 32'hFFEF0230, 32'h0);
    checks++;
    if (rdA !== 32'h0000_5A5A) begin
      failures++;
      $display("FAIL read_230 got=%h exp=5a5a", rdA);
    end
    accA(1'b0, 32'hFFEF0220, 32'h0);
    checks++;
    if (rdA !== 32'h00C0_FFEE || cntA !== 16'd9) begin
      failures++;
      $display("FAIL read_220 got=%h/%h exp=c0ffee/9", rdA, cntA);
    end
  endtask

  task test_saturation;
    logic [15:0] exp [3];
    exp[0] = 16'hFFFE;
    exp[1] = 16'hFFFF;
    exp[2] = 16'hFFFF;
    sel = 1'b0;
    force dut0.acc_cnt = 16'hFFFD;
    tick;
    release dut0.acc_cnt;
    for (int i = 0; i < 3; i++) begin
      RW = 1'b1; addr = 32'hFFEF0200; wd = 32'(i + 1);
      selZ = 1'b1;
      tick;
      checks++;
      if (ackZ !== 1'b1 || cntZ !== exp[i]) begin
        failures++;
        $display("FAIL sat_%0d got=%b/%h exp=1/%h",
                 i, ackZ, cntZ, exp[i]);
      end
      relBus;
    end
    RW = 1'b0; addr = 32'hFFEF0200;
    selZ = 1'b1;
    tick;
    checks++;
    if (ackZ !== 1'b1 || rdZ !== 32'd3 || cntZ !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_read got=%b/%h/%h exp=1/3/ffff",
               ackZ, rdZ, cntZ);
    end
    relBus;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_decode_err;
    test_abort;
    test_back_to_back;
    test_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/svif_mbox_slave.md
# svif_mbox_slave

Slave-side endpoint that sits directly downstream of the bus arbiter on one `svif` slave port. It consumes the arbiter's `sel`/`RW`/`addr`/`DataToSlave` outputs and drives `DataFromSlave`. It implements four 32-bit mailbox words, one per master, with a programmable number of wait states. For each access it adds a one-cycle `ack` pulse, an `err` pulse for undecodable addresses, and a saturating access counter.

## Interface
- `SLV_ID`, default 0: slave index (0–3), matched against `addr[15:12]`.
- `WAIT_CYC`, default 2: wait states per access (0–15).
- `clk` in 1: bus clock, the same clock the arbiter uses.
- `rst` in 1: reset, asynchronous, active-low.
- `sel` in 1: slave select from the arbiter.
- `RW` in 1: 1 = write, 0 = read.
- `addr` in 32: address from the granted master.
- `DataToSlave` in 32: write data.
- `DataFromSlave` out 32: registered read data.
- `ack` out 1: one-cycle access-complete pulse.
- `err` out 1: one-cycle decode-error pulse.
- `busy` out 1: high when the FSM is not in IDLE.
- `acc_cnt` out 16: count of completed accesses, saturating.

## Operation
- **Address decode:** valid when all of the following hold:
  - `addr[31:16]==16'hFFEF`
  - `addr[15:12]==SLV_ID`
  - `addr[11:8]==4'h2`
  - `addr[7:6]==0`
  - `addr[3:0]==0`
- **Index:** `idx = addr[5:4]`, i.e. the master number. For slave 0 the valid addresses are FFEF0200 / 0210 / 0220 / 0230.
- **FSM states:** IDLE, WAIT, ACK, ERR, HOLD.
- **IDLE:**
  - If `sel=1`, latch `RW`, `addr` and `DataToSlave`.
  - Decode fail → ERR.
  - Decode pass with `WAIT_CYC==0` → ACK.
  - Decode pass with `WAIT_CYC>0` → WAIT, loading `wcnt=WAIT_CYC`.
- **WAIT:**
  - If `sel=0` or `addr` differs from the latched address → IDLE (abort: no write, no count).
  - Otherwise, if `wcnt==1` → ACK.
  - Otherwise decrement `wcnt`.
- **Entry into ACK (at that clock edge):**
  - Write: `mbox[idx] <= latched data`.
  - Read: `DataFromSlave <= mbox[idx]`.
  - `acc_cnt` increments, saturating at 16'hFFFF.
- **ACK:** `ack=1` for exactly one cycle, then → HOLD.
- **ERR:** `err=1` for exactly one cycle, with no write, no count and `DataFromSlave` unchanged, then → HOLD.
- **HOLD:**
  - Stays while `sel=1` and `addr` equals the latched address.
  - Goes to IDLE when `sel=0` or `addr` changes.
  - A held grant therefore produces exactly one access.
  - A master switch on the same slave produces a new access via IDLE.
- **`DataFromSlave`:** holds its value until the next read ACK. Writes do not change it.
- **`busy`:** `busy = (state != IDLE)`.
- **Reset (asynchronous, `rst=0`):**
  - State returns to IDLE and `wcnt=0`.
  - All `mbox` words, `DataFromSlave`, `ack`, `err`, `busy` and `acc_cnt` go to 0.
  - An in-flight write is discarded.
- **Out-of-range `WAIT_CYC`:** values above 15 are a parameter error and are not supported.

## Timing
- `sel` sampled in IDLE at edge N: `ack` is high in the cycle after edge N+`WAIT_CYC`. With `WAIT_CYC=0`, `ack` is high in the cycle after edge N.
- The write takes effect, and read data is valid, at the same edge that raises `ack`.
- Minimum spacing between two accesses with `sel` held low for one cycle: `WAIT_CYC`+3 edges.
- `err` is high in the cycle after edge N, regardless of `WAIT_CYC`.
- `sel` or `addr` change during WAIT: abort takes effect at the next edge, and no `ack` is issued.
- `sel=1` at the edge that leaves HOLD for IDLE (address change): the new access is sampled at the following edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset check:** drive `rst` low mid-WAIT, during a write to idx 1 → all outputs 0, `mbox[1]` reads back 0 after release.
- **Write then read, `WAIT_CYC=2`, `SLV_ID=0`:**
  - Write 32'hA5A5_0001 to FFEF0210 → `ack` is one cycle, 2 edges after the sampling edge.
  - Read of FFEF0210 → `DataFromSlave`=A5A50001, `acc_cnt`=2.
- **Decode error:** `sel=1` with `addr`=FFEF1210 on slave 0 → `err` pulse one cycle after the sample, no `ack`, `acc_cnt` unchanged, `mbox` unchanged.
- **Abort:** drop `sel` at the 1st WAIT cycle of a write 0xDEAD to FFEF0200 → no `ack`, `mbox[0]` keeps its old value, FSM back in IDLE.
- **Held grant / master switch:**
  - `sel` held for 20 cycles on FFEF0220 → exactly one `ack`.
  - Then `addr`→FFEF0230 with `sel` still high → second `ack` `WAIT_CYC`+2 edges later.
- **Counter saturation and `WAIT_CYC=0`:** preload `acc_cnt` near 16'hFFFF via 3 accesses with `WAIT_CYC=0` and a force → `acc_cnt` stops at FFFF, each `ack` arrives 1 cycle after the sample.
